// File: rtl/mem_line_server_pkg.sv
// Shared types and helpers for the line server: FSM states, port ids and line indexing.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mls_state_t;
  typedef enum logic {GNT_IC, GNT_DC} mls_port_t;

  localparam int LINE_W = 128;
  localparam int OFF    = 4;
  localparam int IDX    = 10;

  // Byte offset bits are dropped and everything above the index field wraps away.
  function automatic logic [31:0] line_index(input logic [63:0] addr, input int off, input int idx);
    logic [63:0] shifted;
    shifted = addr >> off;
    return 32'(shifted & ((64'd1 << idx) - 64'd1));
  endfunction

endpackage

// File: rtl/mem_line_server_rr_arb2.sv
// Two-port round-robin arbiter: combinational grant, last winner remembered on accept.
module rr_arb2
  import mem_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      ic_req,
  input  logic      dc_req,
  input  logic      accept,
  output mls_port_t grant
);

  mls_port_t last_grant;

  always_comb begin
    grant = GNT_IC;
    if (ic_req && dc_req)
      grant = (last_grant == GNT_DC) ? GNT_IC : GNT_DC;
    else if (dc_req)
      grant = GNT_DC;
  end

  // Reset value DC makes the first tie go to the icache.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= GNT_DC;
    else if (accept)
      last_grant <= grant;
  end

endmodule

// File: rtl/mem_line_server.sv
// Backing memory serving icache fills and dcache fills/writebacks, one
// fixed-latency transaction at a time.
module mem_line_server
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LINES  = 1024,
  parameter int LATENCY    = 5,
  localparam int LINE_BITS = LINE_WORDS * WORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  output logic                 ic_ack,
  output logic [LINE_BITS-1:0] ic_rdata,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_ack,
  output logic [LINE_BITS-1:0] dc_rdata
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = $clog2(MEM_LINES);
  localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mls_state_t           state;
  mls_port_t            grant;
  mls_port_t            port_q;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_BITS-1:0]  idx_q;
  logic                 we_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [IDX_BITS-1:0]  ic_idx;
  logic [IDX_BITS-1:0]  dc_idx;
  logic [LINE_BITS-1:0] rd_line;
  logic                 accept;
  logic                 finish;

  logic [LINE_BITS-1:0] mem [MEM_LINES];
  logic                 written [MEM_LINES];

  // Power-on contents: word k of the flat word space holds k.
  function automatic logic [LINE_BITS-1:0] init_line(input logic [IDX_BITS-1:0] idx);
    logic [LINE_BITS-1:0] line;
    line = '0;
    for (int j = 0; j < LINE_WORDS; j++)
      line[j*WORD_W +: WORD_W] = WORD_W'(int'(idx) * LINE_WORDS + j);
    return line;
  endfunction

  assign ic_idx  = IDX_BITS'(line_index(64'(ic_addr), OFF_BITS, IDX_BITS));
  assign dc_idx  = IDX_BITS'(line_index(64'(dc_addr), OFF_BITS, IDX_BITS));
  assign accept  = (state == IDLE) && (ic_req || dc_req);
  assign finish  = (state == BUSY) && (cnt == '0);
  assign rd_line = written[idx_q] ? mem[idx_q] : init_line(idx_q);

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .ic_req (ic_req),
    .dc_req (dc_req),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      port_q   <= GNT_IC;
      cnt      <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ic_ack   <= 1'b0;
      dc_ack   <= 1'b0;
      ic_rdata <= '0;
      dc_rdata <= '0;
    end else begin
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            port_q  <= grant;
            idx_q   <= (grant == GNT_IC) ? ic_idx : dc_idx;
            we_q    <= (grant == GNT_DC) && dc_we;
            wdata_q <= dc_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
            if (port_q == GNT_IC) begin
              ic_ack   <= 1'b1;
              ic_rdata <= rd_line;
            end else begin
              dc_ack <= 1'b1;
              if (!we_q)
                dc_rdata <= rd_line;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside reset; a write only lands on the edge into RESP,
  // so an aborted transaction never touches the array.
  always_ff @(posedge clk) begin
    if (finish && we_q) begin
      mem[idx_q]     <= wdata_q;
      written[idx_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_line_server.sv
// Self-checking bench for mem_line_server: vector table, hand sequences, random traffic vs model.
module tb_mem_line_server;

  localparam int LATENCY    = 5;
  localparam int MEM_LINES  = 1024;
  localparam int LINE_WORDS = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ic_req = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         ic_ack;
  logic [127:0] ic_rdata;
  logic         dc_req = 1'b0;
  logic         dc_we = 1'b0;
  logic [31:0]  dc_addr = '0;
  logic [127:0] dc_wdata = '0;
  logic         dc_ack;
  logic [127:0] dc_rdata;

  int checks = 0;
  int errors = 0;

  int unsigned model [MEM_LINES*LINE_WORDS];

  typedef struct {
    bit           is_dc;
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vec [7];

  always #5 clk = ~clk;

  mem_line_server dut (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_ack   (ic_ack),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_ack   (dc_ack),
    .dc_rdata (dc_rdata)
  );

  function automatic int unsigned line_base(input logic [31:0] addr);
    return ((int'(addr) >>> 0) >= 0 ? ((addr / 16) % MEM_LINES) : ((addr / 16) % MEM_LINES)) * LINE_WORDS;
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] addr);
    logic [127:0] r;
    int unsigned  b;
    b = line_base(addr);
    for (int j = 0; j < LINE_WORDS; j++) r[j*32 +: 32] = model[b + j];
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [127:0] d);
    int unsigned b;
    b = line_base(addr);
    for (int j = 0; j < LINE_WORDS; j++) model[b + j] = d[j*32 +: 32];
  endfunction

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endfunction

  // Acks must be single-cycle pulses and never overlap.
  logic prev_ic = 1'b0;
  logic prev_dc = 1'b0;
  always @(negedge clk) begin
    if (ic_ack || dc_ack) begin
      checks++;
      if ((ic_ack && dc_ack) || (ic_ack && prev_ic) || (dc_ack && prev_dc)) begin
        errors++;
        $display("FAIL ack_pulse ic_ack=%0b dc_ack=%0b prev_ic=%0b prev_dc=%0b want exclusive one-cycle pulses",
                 ic_ack, dc_ack, prev_ic, prev_dc);
      end
    end
    prev_ic <= ic_ack;
    prev_dc <= dc_ack;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single transaction on one port, starting from a negedge with the server idle.
  task automatic do_txn(input bit is_dc, input bit we, input logic [31:0] addr,
                        input logic [127:0] wdata, output logic [127:0] rd, output int lat);
    logic [127:0] other;
    bit           seen;
    seen  = 1'b0;
    lat   = 0;
    rd    = '0;
    other = is_dc ? ic_rdata : dc_rdata;
    if (is_dc) begin
      dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wdata;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    for (int n = 1; n <= LATENCY + 10 && !seen; n++) begin
      step();
      if (is_dc ? dc_ack : ic_ack) begin
        seen = 1'b1;
        lat  = n;
        rd   = is_dc ? dc_rdata : ic_rdata;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    chk("ack_seen", 128'(seen), 128'(1));
    step();
    chk("ack_drop", 128'(is_dc ? dc_ack : ic_ack), 128'(0));
    chk("other_rdata_hold", is_dc ? ic_rdata : dc_rdata, other);
  endtask

  initial begin
    logic [127:0] rd;
    logic [127:0] rd_a;
    logic [127:0] rd_b;
    logic [127:0] rd_c;
    int           lat;
    int           ic_hits[$];
    int           dc_hits[$];
    bit           saw;
    bit           is_dc;
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wd;

    for (int k = 0; k < MEM_LINES*LINE_WORDS; k++) model[k] = k;

    vec[0] = '{is_dc: 1'b0, we: 1'b0, addr: 32'h40,   wdata: '0, exp: {32'd19, 32'd18, 32'd17, 32'd16}};
    vec[1] = '{is_dc: 1'b1, we: 1'b1, addr: 32'h80,   wdata: {4{32'hDEADBEEF}}, exp: '0};
    vec[2] = '{is_dc: 1'b1, we: 1'b0, addr: 32'h8C,   wdata: '0, exp: {4{32'hDEADBEEF}}};
    vec[3] = '{is_dc: 1'b0, we: 1'b0, addr: 32'h10,   wdata: '0, exp: {32'd7, 32'd6, 32'd5, 32'd4}};
    vec[4] = '{is_dc: 1'b0, we: 1'b0, addr: 32'h4010, wdata: '0, exp: {32'd7, 32'd6, 32'd5, 32'd4}};
    vec[5] = '{is_dc: 1'b1, we: 1'b0, addr: 32'h4084, wdata: '0, exp: {4{32'hDEADBEEF}}};
    vec[6] = '{is_dc: 1'b0, we: 1'b0, addr: 32'h8F,   wdata: '0, exp: {4{32'hDEADBEEF}}};

    // Reset state
    step(); step();
    chk("rst_ic_ack", 128'(ic_ack), 128'(0));
    chk("rst_dc_ack", 128'(dc_ack), 128'(0));
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    reset = 1'b0;
    step();

    // Tie after reset goes to IC; DC follows at P7; a fresh tie at P7 then favours DC.
    ic_req = 1'b1; ic_addr = 32'h40;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h30;
    for (int n = 1; n <= 22; n++) begin
      step();
      if (ic_ack) begin
        ic_hits.push_back(n);
        if (ic_hits.size() == 1) rd_a = ic_rdata; else rd_c = ic_rdata;
        ic_req = 1'b0;
      end
      if (dc_ack) begin
        dc_hits.push_back(n);
        rd_b = dc_rdata;
        dc_req = 1'b0;
      end
      if (n == 7) begin
        ic_req = 1'b1; ic_addr = 32'h50;
      end
    end
    chk("tie_ic_count", 128'(ic_hits.size()), 128'(2));
    chk("tie_dc_count", 128'(dc_hits.size()), 128'(1));
    chk("tie_ic_first_cycle", 128'(ic_hits.size() > 0 ? ic_hits[0] : -1), 128'(6));
    chk("tie_dc_cycle", 128'(dc_hits.size() > 0 ? dc_hits[0] : -1), 128'(13));
    chk("tie_ic_second_cycle", 128'(ic_hits.size() > 1 ? ic_hits[1] : -1), 128'(20));
    chk("tie_ic_rdata0", rd_a, {32'd19, 32'd18, 32'd17, 32'd16});
    chk("tie_dc_rdata", rd_b, {32'd15, 32'd14, 32'd13, 32'd12});
    chk("tie_ic_rdata1", rd_c, {32'd23, 32'd22, 32'd21, 32'd20});

    // Vector table
    for (int i = 0; i < 7; i++) begin
      do_txn(vec[i].is_dc, vec[i].we, vec[i].addr, vec[i].wdata, rd, lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(LATENCY + 1));
      if (vec[i].we) model_write(vec[i].addr, vec[i].wdata);
      else begin
        chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp);
        chk($sformatf("vec%0d_model", i), rd, model_line(vec[i].addr));
      end
    end

    // Reset mid-writeback aborts it without committing.
    saw = 1'b0;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h20; dc_wdata = '1;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (dc_ack) saw = 1'b1;
    end
    reset = 1'b1;
    dc_req = 1'b0;
    step();
    chk("midrst_dc_ack", 128'(dc_ack), 128'(0));
    chk("midrst_dc_rdata", dc_rdata, '0);
    step();
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (dc_ack || ic_ack) saw = 1'b1;
    end
    chk("midrst_no_ack", 128'(saw), 128'(0));
    do_txn(1'b1, 1'b0, 32'h20, '0, rd, lat);
    chk("midrst_fill", rd, {32'd11, 32'd10, 32'd9, 32'd8});

    // Held ic_req is served again as a new transaction.
    ic_hits.delete();
    ic_req = 1'b1; ic_addr = 32'h60;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (ic_ack) begin
        ic_hits.push_back(n);
        rd_a = ic_rdata;
        if (ic_hits.size() == 2) ic_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    chk("held_count", 128'(ic_hits.size()), 128'(2));
    chk("held_first", 128'(ic_hits.size() > 0 ? ic_hits[0] : -1), 128'(6));
    chk("held_second", 128'(ic_hits.size() > 1 ? ic_hits[1] : -1), 128'(13));
    chk("held_rdata", rd_a, {32'd27, 32'd26, 32'd25, 32'd24});

    // Random traffic against the flat-word model.
    for (int i = 0; i < 40; i++) begin
      is_dc = 1'($urandom_range(0, 1));
      we    = is_dc && ($urandom_range(0, 2) == 0);
      addr  = $urandom;
      if ($urandom_range(0, 1) == 1) addr = 32'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
      wd    = {$urandom, $urandom, $urandom, $urandom};
      do_txn(is_dc, we, addr, wd, rd, lat);
      chk("rand_latency", 128'(lat), 128'(LATENCY + 1));
      if (we) model_write(addr, wd);
      else chk($sformatf("rand%0d_rdata_%h", i, addr), rd, model_line(addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
